// File: rtl/register_file.sv
// register_file: multi-ported GPR file for the RISC core datapath.
// Two combinational read ports (RD1/RD2) and one synchronous write port
// (A3/WD3/WE3). Register 0 reads as zero and has no storage. Addresses at
// or above NUM_REGS are unmapped: writes to them are dropped and reads
// return zero. There is no write-to-read bypass; same-cycle hazards are
// resolved by the pipeline forwarding unit.
module register_file #(
  parameter int WIDTH    = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              WE3,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  input  logic [ADDR_W-1:0] A3,
  input  logic [WIDTH-1:0]  WD3,
  output logic [WIDTH-1:0]  RD1,
  output logic [WIDTH-1:0]  RD2
);

  // Storage for registers 1..NUM_REGS-1; index 0 is never instantiated.
  logic [WIDTH-1:0] r_regs [1:NUM_REGS-1];

  logic [WIDTH-1:0] w_rd1;
  logic [WIDTH-1:0] w_rd2;

  // Write port: rst low clears everything at once and blocks writes. Each
  // register loads only on an exact address match, so A3=0, unmapped
  // addresses and an unknown A3 never disturb stored state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (WE3) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (A3 == ADDR_W'(i)) begin
          r_regs[i] <= WD3;
        end
      end
    end
  end

  // Read port 1: match-based mux, so address 0 and unmapped addresses fall
  // through to the zero default.
  always_comb begin
    w_rd1 = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (A1 == ADDR_W'(i)) begin
        w_rd1 = r_regs[i];
      end
    end
  end

  // Read port 2: identical to port 1 and fully independent of it.
  always_comb begin
    w_rd2 = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (A2 == ADDR_W'(i)) begin
        w_rd2 = r_regs[i];
      end
    end
  end

  assign RD1 = w_rd1;
  assign RD2 = w_rd2;

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed scenarios plus randomized traffic for
// register_file, checked against an array model of the architectural state.
module tb_register_file;

  localparam int WIDTH    = 32;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;

  logic              clk;
  logic              rst;
  logic              WE3;
  logic [ADDR_W-1:0] A1;
  logic [ADDR_W-1:0] A2;
  logic [ADDR_W-1:0] A3;
  logic [WIDTH-1:0]  WD3;
  logic [WIDTH-1:0]  RD1;
  logic [WIDTH-1:0]  RD2;

  int checks   = 0;
  int failures = 0;

  // Architectural state as the core sees it; index 0 is always zero.
  logic [WIDTH-1:0] model [0:NUM_REGS-1];

  register_file #(
    .WIDTH(WIDTH),
    .NUM_REGS(NUM_REGS),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .WE3(WE3),
    .A1(A1),
    .A2(A2),
    .A3(A3),
    .WD3(WD3),
    .RD1(RD1),
    .RD2(RD2)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net in case anything stalls.
  initial begin
    #200000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%08h required=%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] ref_read(input int a);
    if (a == 0 || a >= NUM_REGS) return '0;
    return model[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
  endtask

  // Present a write for one rising edge; the model follows the rules:
  // only with rst high, WE3 high, and a nonzero mapped address.
  task automatic do_write(input logic we, input int a, input logic [WIDTH-1:0] d);
    @(negedge clk);
    WE3 = we;
    A3  = ADDR_W'(a);
    WD3 = d;
    @(posedge clk);
    if (rst && we && a != 0 && a < NUM_REGS) model[a] = d;
    #1;
    WE3 = 1'b0;
  endtask

  // Drive read addresses and check both ports without waiting for an edge.
  task automatic read_now(input int a1, input int a2);
    A1 = ADDR_W'(a1);
    A2 = ADDR_W'(a2);
    #1;
    check($sformatf("rd1[%0d]", a1), RD1, ref_read(a1));
    check($sformatf("rd2[%0d]", a2), RD2, ref_read(a2));
  endtask

  task automatic read_check(input int a1, input int a2);
    @(negedge clk);
    read_now(a1, a2);
  endtask

  initial begin
    rst = 1'b0;
    WE3 = 1'b0;
    A1  = '0;
    A2  = '0;
    A3  = '0;
    WD3 = '0;
    model_clear();

    // Reset state: everything reads zero while held in reset.
    repeat (2) @(posedge clk);
    for (int i = 0; i < NUM_REGS; i += 4) read_check(i, NUM_REGS - 1 - i);
    @(negedge clk);
    rst = 1'b1;
    read_check(7, 31);

    // Basic write/read.
    do_write(1'b1, 3, 32'h0000_000F);
    read_check(3, 0);
    check("basic_r3", RD1, 32'h0000_000F);
    do_write(1'b1, 5, 32'h0000_FFFF);
    read_check(3, 5);
    check("basic_r5", RD2, 32'h0000_FFFF);

    // Multiple registers and write enable low.
    do_write(1'b1, 6, 32'h0000_0001);
    do_write(1'b1, 1, 32'h0000_ABCD);
    do_write(1'b0, 1, 32'hDEAD_BEEF);
    do_write(1'b0, 1, 32'hDEAD_BEEF);
    read_check(1, 6);
    check("we0_r1", RD1, 32'h0000_ABCD);
    check("we0_r6", RD2, 32'h0000_0001);

    // Register 0 write is discarded, others untouched.
    do_write(1'b1, 0, 32'hFFFF_FFFF);
    read_check(0, 3);
    check("r0_zero", RD1, 32'h0000_0000);
    for (int i = 1; i < 8; i++) read_check(i, i);

    // Asynchronous reset between edges: visible with no clock edge.
    A1 = 5'd1;
    A2 = 5'd6;
    @(posedge clk);
    #2;
    check("pre_rst_r1", RD1, 32'h0000_ABCD);
    rst = 1'b0;
    model_clear();
    read_now(1, 6);
    read_now(3, 5);
    check("async_r3", RD1, '0);

    // Writes ignored while in reset.
    do_write(1'b1, 6, 32'h0000_0001);
    read_check(6, 1);
    check("rst_wr_r6", RD1, '0);

    // Release and write resumes on first edge.
    @(negedge clk);
    rst = 1'b1;
    do_write(1'b1, 1, 32'h0000_ABCD);
    read_check(1, 6);
    check("post_rst_r1", RD1, 32'h0000_ABCD);

    // Read during write, no bypass.
    do_write(1'b1, 4, 32'h1111_1111);
    @(negedge clk);
    A1  = 5'd4;
    A2  = 5'd4;
    A3  = 5'd4;
    WD3 = 32'h2222_2222;
    WE3 = 1'b1;
    #1;
    check("rdw_before1", RD1, 32'h1111_1111);
    check("rdw_before2", RD2, 32'h1111_1111);
    @(posedge clk);
    model[4] = 32'h2222_2222;
    #1;
    WE3 = 1'b0;
    check("rdw_after1", RD1, 32'h2222_2222);
    check("rdw_after2", RD2, 32'h2222_2222);

    // Full sweep.
    for (int i = 1; i < NUM_REGS; i++) do_write(1'b1, i, WIDTH'(i) * 32'h0101_0101);
    for (int i = 0; i < NUM_REGS; i++) begin
      read_check(i, NUM_REGS - 1 - i);
      check($sformatf("sweep_%0d", i), RD1, (i == 0) ? 32'h0 : WIDTH'(i) * 32'h0101_0101);
    end

    // Randomized traffic, occasional async reset pulses.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 49) == 0) begin
        @(posedge clk);
        #3;
        rst = 1'b0;
        model_clear();
        read_now(int'($urandom_range(0, NUM_REGS - 1)), int'($urandom_range(0, NUM_REGS - 1)));
        do_write(1'b1, int'($urandom_range(1, NUM_REGS - 1)), WIDTH'($urandom));
        @(negedge clk);
        rst = 1'b1;
      end
      do_write(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, NUM_REGS - 1)),
               WIDTH'($urandom));
      read_check(int'($urandom_range(0, NUM_REGS - 1)), int'($urandom_range(0, NUM_REGS - 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- Multi-ported general-purpose register file for the RISC core datapath.
- Provides two combinational read ports (RD1/RD2, feeding ALU operands) and one synchronous write port (A3/WD3/WE3, from writeback).
- Register 0 is hardwired to zero, RISC-V style.
- Asynchronous active-low reset clears all registers.

Parameters:
- WIDTH, 32, data width of each register and of all data ports.
- NUM_REGS, 32, number of architectural registers; legal range 2..32.
- ADDR_W, 5, address width of A1/A2/A3; must satisfy 2^ADDR_W >= NUM_REGS.

Ports:
- clk  input  1  clock; all writes occur on the rising edge.
- rst  input  1  asynchronous, active-low reset; 0 clears every register.
- WE3  input  1  write enable for port 3.
- A1  input  ADDR_W  read address, port 1.
- A2  input  ADDR_W  read address, port 2.
- A3  input  ADDR_W  write address, port 3.
- WD3  input  WIDTH  write data, port 3.
- RD1  output  WIDTH  read data for A1 (combinational).
- RD2  output  WIDTH  read data for A2 (combinational).

Behaviour:
- Storage: NUM_REGS registers of WIDTH bits each; reg[0] is constant zero and has no storage.
- Reset:
  - rst=0 immediately clears all registers to 0, without waiting for a clock edge.
  - While rst=0, every write is ignored.
  - RD1 and RD2 read 0 for every address while rst=0 and after reset release until a new write.
- Write:
  - On a rising clk edge with rst=1, WE3=1, A3!=0 and A3<NUM_REGS, reg[A3] <= WD3.
  - Write latency is one edge: the new value is visible on the read ports after that edge.
  - WE3=0 leaves all registers unchanged.
- Ignored writes: writes with A3=0 or A3>=NUM_REGS are discarded, with no side effects on any register.
- Read:
  - RD1 = reg[A1] and RD2 = reg[A2], purely combinational with zero cycles of latency.
  - Reads of address 0 or of any address >= NUM_REGS return 0.
- Read during write, same address: there is no internal bypass.
  - Before the edge, RD shows the old value.
  - After the edge, RD shows WD3.
  - The pipeline forwarding unit handles same-cycle hazards.
- Dual reads:
  - A1 and A2 are fully independent.
  - A1==A2 returns the same value on both ports.
  - Both ports may equal A3.
- Reset mid-operation: rst falling in the middle of a cycle clears the registers at once. A write edge that coincides with rst=0 is lost.
- Reset release: writes resume on the first rising edge at which rst=1.
- X-safety: unknown A1/A2 inputs must not corrupt stored state. Only WE3=1 with a known A3 modifies state.

Test Plan:
- Basic write/read: rst=1, WE3=1, A3=3, WD3=0x0000000F, one edge; then A1=3 -> RD1=0x0000000F. Write A3=5, WD3=0x0000FFFF; A2=5 -> RD2=0x0000FFFF, RD1 still 0x0000000F.
- Multiple registers and write enable: write r6=0x00000001 and r1=0x0000ABCD. Then set WE3=0, A3=1, WD3=0xDEADBEEF for 2 edges -> r1 still reads 0x0000ABCD, r6 reads 0x00000001.
- Register 0: WE3=1, A3=0, WD3=0xFFFFFFFF, one edge -> RD1 with A1=0 reads 0, and all other registers are unchanged.
- Asynchronous reset:
  - With r1, r3, r5, r6 loaded, drive rst=0 between clock edges -> RD1/RD2 read 0 for those addresses immediately, with no edge needed.
  - While rst=0, attempt to write r6=0x00000001 -> r6 still reads 0.
  - Release rst=1 and write r1=0x0000ABCD -> it reads 0x0000ABCD after the next edge.
- Read-during-write: r4=0x11111111; A1=4, A2=4, WE3=1, A3=4, WD3=0x22222222 -> before the edge, RD1=RD2=0x11111111; after the edge, both read 0x22222222.
- Full sweep: write reg[i]=i*0x01010101 for i=1..31, then read every pair (A1=i, A2=31-i) -> each port returns its stored value, and address 0 returns 0.
